// File: rtl/keypad_debouncer.sv
// Keypad column debouncer: 2-flop synchronizer, stability window,
// multi-key detection/rejection and press/release event pulses.
module keypad_debouncer #(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned STABLE_CYCLES = 50000,
   parameter bit          ACTIVE_LOW    = 1'b0,
   parameter bit          REJECT_MULTI  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sig_in,
   output logic [WIDTH-1:0] sig_out,
   output logic             key_pressed,
   output logic             press_pulse,
   output logic             release_pulse,
   output logic             multi_key
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             multi_q, multi_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic [WIDTH-1:0] sync1_d;
   logic             cand_multi;
   logic [WIDTH-1:0] tgt_out;

   assign sync1_d = ACTIVE_LOW ? ~sig_in : sig_in;

   // x & (x-1) clears the lowest set bit; nonzero means 2+ bits set
   assign cand_multi = |(cand_q & (cand_q - WIDTH'(1)));
   assign tgt_out = (REJECT_MULTI && cand_multi) ? out_q : cand_q;

   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      multi_d = multi_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end else if ((tgt_out != out_q) || (cand_multi != multi_q)) begin
         // Once committed, state matches cand so saturation cannot re-fire
         out_d   = tgt_out;
         multi_d = cand_multi;
         press_d = (tgt_out != '0) && (tgt_out != out_q);
         rel_d   = (out_q != '0) && (tgt_out == '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         multi_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync1_q;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         multi_q <= multi_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign sig_out       = out_q;
   assign key_pressed   = |out_q;
   assign press_pulse   = press_q;
   assign release_pulse = rel_q;
   assign multi_key     = multi_q;

endmodule

// File: doc/keypad_debouncer.md
Name: keypad_debouncer

Overview:
- Parametrised successor to the 4-column debouncer in the keypad scanner path.
- Sits between the column input pins and the key decoder/scan FSM.
- Adds:
  - WIDTH-wide, polarity-configurable input with a 2-flop synchronizer.
  - Configurable stability window.
  - Multi-key detection and optional rejection.
  - Single-cycle press and release event pulses.

Parameters:
- WIDTH, 4, number of input channels (columns); must be >= 1.
- STABLE_CYCLES, 50000, consecutive identical samples required before a pattern is accepted; must be >= 2.
- ACTIVE_LOW, 0, when 1, sig_in is inverted before synchronisation, so an internal 1 always means "active".
- REJECT_MULTI, 1, when 1, stable patterns with more than one active bit are not committed to sig_out.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- sig_in  in  WIDTH  raw, asynchronous channel inputs.
- sig_out  out  WIDTH  debounced, committed pattern (active-high).
- key_pressed  out  1  high while sig_out != 0.
- press_pulse  out  1  one-cycle pulse when a new nonzero pattern is committed.
- release_pulse  out  1  one-cycle pulse when a commit changes sig_out from nonzero to zero.
- multi_key  out  1  high while the last stable pattern had more than one active bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchronizer, candidate and counter are all cleared to 0 (inactive).
  - sig_out=0; key_pressed, press_pulse, release_pulse and multi_key are all 0.
  - Takes effect immediately, including mid-count; no partial count survives.
- Input path:
  - sync1 <= (ACTIVE_LOW ? ~sig_in : sig_in); sync2 <= sync1.
  - Only sync2 is used downstream.
- Candidate/counter:
  - Counter width is $clog2(STABLE_CYCLES).
  - If sync2 != cand: cand <= sync2 and cnt <= 0.
  - Else if cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - Otherwise cnt saturates at STABLE_CYCLES-1.
- Commit point:
  - Defined as the cycle where cnt == STABLE_CYCLES-1, sync2 == cand, and cand differs from the current committed state.
  - Committed state is sig_out; under rejection it is the multi_key/sig_out pair.
  - A commit is evaluated once per stable pattern; saturation never re-fires pulses.
- Latency:
  - Count the first rising edge that samples a new sig_in value as edge 1.
  - If the input is held constant, sig_out updates at edge STABLE_CYCLES+3.
  - Any change before then restarts the window.
- Bounce: any pattern stable for fewer than STABLE_CYCLES samples never reaches sig_out, and no pulses are generated.
- Multi-key (popcount(cand) > 1 at commit):
  - REJECT_MULTI=1: sig_out holds its previous value, multi_key <= 1, no pulses.
  - REJECT_MULTI=0: sig_out <= cand, multi_key <= 1, and pulses follow the normal rules.
  - Any later commit of a pattern with popcount <= 1 clears multi_key.
- Pulse rules (registered, asserted in the cycle after the commit edge, exactly 1 cycle wide):
  - old sig_out == 0, new != 0: press_pulse.
  - old sig_out != 0, new == 0: release_pulse.
  - nonzero to different nonzero: press_pulse only, no release_pulse.
  - press_pulse and release_pulse are never high simultaneously.
- key_pressed is |sig_out; it may be combinational from the sig_out register.
- Zero pattern: all-zero is a normal pattern and follows the same window (the release is debounced too).

Test Plan (bench uses WIDTH=4, STABLE_CYCLES=4):
- Reset: hold reset=0 for 3 cycles with sig_in=4'b1111 -> all outputs 0 throughout. Release with sig_in=0000 for 20 cycles -> outputs stay 0, no pulses.
- Clean press/release: sig_in=0001 held -> sig_out=0001 and key_pressed=1 at edge 7, press_pulse high for exactly 1 cycle. Then sig_in=0000 held -> sig_out=0000 at edge 7, release_pulse 1 cycle.
- Bounce: toggle sig_in 0010/0000 every 2 cycles for 20 cycles, then hold 0010 -> sig_out stays 0000 during bouncing, becomes 0010 at edge 7 after the final settle, with one press_pulse.
- Multi-key:
  - REJECT_MULTI=1, from sig_out=0001, apply 0110 -> sig_out stays 0001, multi_key=1 at edge 7, no pulses. Then apply 0000 -> sig_out=0000, multi_key=0, one release_pulse.
  - REJECT_MULTI=0, same 0110 stimulus -> sig_out=0110, multi_key=1.
- Direct change: from sig_out=0001, apply 1000 -> sig_out=1000 at edge 7, one press_pulse, release_pulse stays 0.
- Reset mid-count and polarity:
  - Assert reset at edge 3 of a pending 0100 -> outputs 0 immediately (before the next clk edge). After release, a full 7-edge window is required.
  - ACTIVE_LOW=1 with sig_in=1110 -> sig_out=0001.
